// File: rtl/pwm_multi_fx.sv
// pwm_multi_fx: multi-channel LED PWM engine sharing one period counter.
// Each channel is off, static, breathing or blinking; new settings swap in only at period boundaries.
module pwm_multi_fx #(
  parameter int NCH        = 8,
  parameter int PWM_W      = 8,
  parameter int PRE_DIV    = 4,
  parameter int BRTH_DIV   = 2,
  parameter int BLINK_DIV  = 64,
  parameter int ACTIVE_LOW = 1,
  parameter int AW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             iwe,
  input  logic [AW-1:0]    iaddr,
  input  logic [PWM_W+1:0] iwdata,
  output logic [NCH-1:0]   owvpwm,
  output logic             oprd_end,
  output logic [PWM_W-1:0] olevel
);

  localparam int PCW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam int BRW = (BRTH_DIV > 1) ? $clog2(BRTH_DIV) : 1;
  localparam int BLW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PWM_W-1:0] MAX  = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] LAST = MAX - 1'b1;
  localparam logic             POL  = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STATIC = 2'd1,
    MODE_BREATH = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [PCW-1:0]   pcnt;
  logic [PWM_W-1:0] cnt;
  logic             tick;
  logic             period_end;
  logic [BRW-1:0]   brth_cnt;
  logic [BLW-1:0]   blink_cnt;
  logic [PWM_W-1:0] level;
  dir_t             dir;
  logic             blink;
  mode_t            stg_mode [NCH];
  mode_t            act_mode [NCH];
  logic [PWM_W-1:0] stg_duty [NCH];
  logic [PWM_W-1:0] act_duty [NCH];
  logic [PWM_W-1:0] eff      [NCH];
  logic [NCH-1:0]   raw;

  assign tick       = (pcnt == PCW'(PRE_DIV - 1));
  assign period_end = tick && (cnt == LAST);
  assign olevel     = level;

  always_ff @(posedge iclk) begin
    if (irst) begin
      pcnt <= '0;
      cnt  <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) cnt <= period_end ? '0 : cnt + 1'b1;
    end
  end

  // Breathing level bounces 0..MAX..0 without repeating endpoints; blink phase starts on.
  always_ff @(posedge iclk) begin
    if (irst) begin
      brth_cnt  <= '0;
      blink_cnt <= '0;
      level     <= '0;
      dir       <= DIR_UP;
      blink     <= 1'b1;
    end else if (period_end) begin
      if (brth_cnt == BRW'(BRTH_DIV - 1)) begin
        brth_cnt <= '0;
        if (dir == DIR_UP) begin
          level <= level + 1'b1;
          if (level == LAST) dir <= DIR_DOWN;
        end else begin
          level <= level - 1'b1;
          if (level == PWM_W'(1)) dir <= DIR_UP;
        end
      end else begin
        brth_cnt <= brth_cnt + 1'b1;
      end
      if (blink_cnt == BLW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Active settings take the pre-edge staged value, so a write on period_end waits a full period.
  always_ff @(posedge iclk) begin
    for (int i = 0; i < NCH; i++) begin
      if (irst) begin
        stg_mode[i] <= MODE_OFF;
        stg_duty[i] <= '0;
        act_mode[i] <= MODE_OFF;
        act_duty[i] <= '0;
      end else begin
        if (period_end) begin
          act_mode[i] <= stg_mode[i];
          act_duty[i] <= stg_duty[i];
        end
        if (iwe && (iaddr == AW'(i))) begin
          stg_mode[i] <= mode_t'(iwdata[PWM_W+1:PWM_W]);
          stg_duty[i] <= iwdata[PWM_W-1:0];
        end
      end
    end
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < NCH; i++) begin
      eff[i] = '0;
      case (act_mode[i])
        MODE_OFF:    eff[i] = '0;
        MODE_STATIC: eff[i] = act_duty[i];
        MODE_BREATH: eff[i] = level;
        MODE_BLINK:  eff[i] = blink ? act_duty[i] : '0;
        default:     eff[i] = '0;
      endcase
      raw[i] = (cnt < eff[i]);
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      owvpwm   <= {NCH{POL}};
      oprd_end <= 1'b0;
    end else begin
      owvpwm   <= raw ^ {NCH{POL}};
      oprd_end <= period_end;
    end
  end

endmodule

// File: doc/pwm_multi_fx.md
# pwm_multi_fx

Parametrised multi-channel PWM engine driving NCH LED outputs from one shared counter. Each channel has its own mode (off, static duty, breathing, blink) and duty value, written through a simple register port and applied glitch-free at PWM period boundaries. It replaces fixed-function LED/RGB PWM generators at the board top level: one instance drives the discrete LED bank plus both RGB LEDs.

## Interface
- NCH, 8: number of PWM channels (≥1)
- PWM_W, 8: duty resolution in bits; MAX = 2^PWM_W − 1
- PRE_DIV, 4: iclk cycles per PWM counter tick (≥1)
- BRTH_DIV, 2: PWM periods per breathing level step (≥1)
- BLINK_DIV, 64: PWM periods per blink half-phase (≥1)
- ACTIVE_LOW, 1: 1 = outputs inverted (LED on = 0)
- AW: derived, max($clog2(NCH),1)

Ports:
- iclk  in  1  clock
- irst  in  1  reset; synchronous, active-high
- iwe  in  1  write strobe, one write per cycle
- iaddr  in  AW  channel index
- iwdata  in  PWM_W+2  {mode[1:0], duty[PWM_W-1:0]}
- owvpwm  out  NCH  PWM outputs, registered
- oprd_end  out  1  one-cycle pulse per PWM period
- olevel  out  PWM_W  current breathing level

## Operation
- Prescaler pcnt counts 0..PRE_DIV−1; tick when pcnt == PRE_DIV−1.
- PWM counter cnt counts 0..MAX−1 on ticks; period_end = tick && cnt == MAX−1; cnt wraps to 0. Period = MAX·PRE_DIV clocks.
- Per channel: staged {mode,duty} (written by iwe) and active {mode,duty}. Active loads staged value (pre-edge contents) on period_end only. A write coinciding with period_end lands in staged and takes effect at the following period_end.
- iaddr ≥ NCH: write ignored.
- Modes (active): 0 off → eff = 0; 1 static → eff = duty; 2 breath → eff = level; 3 blink → eff = blink ? duty : 0.
- Breathing: level, dir. Every BRTH_DIV-th period_end: if up, level+1, switching dir to down when new level == MAX; if down, level−1, switching to up when new level == 0. Sequence 0,1..MAX,MAX−1..0,1..; no repeated endpoints.
- Blink: bit toggles on every BLINK_DIV-th period_end.
- Level, blink and active registers change only at period_end, so eff is constant across a period.
- Output: raw[i] = (cnt < eff[i]); owvpwm[i] ← raw[i] XOR ACTIVE_LOW. eff = 0 → never on; eff = MAX → on for whole period.
- olevel = level register.

## Timing
- Reset (irst high at edge, any state, iwe ignored): pcnt=0, cnt=0, all staged/active = {0,0}, level=0, dir=up, blink=1, breath/blink divider counters=0, oprd_end=0, owvpwm = {NCH{ACTIVE_LOW}}.
- owvpwm lags cnt by one iclk (registered compare).
- oprd_end is high for exactly one iclk: the cycle immediately after the period_end edge (first cycle with cnt=0).
- Write → output: new duty visible on owvpwm starting 1 clock after the first period_end following the write edge.
- Channel on-time per period = eff·PRE_DIV clocks, starting at cnt=0.
- Breath full cycle = 2·MAX·BRTH_DIV periods; blink full cycle = 2·BLINK_DIV periods.

## Test plan
Config for all: NCH=4, PWM_W=4 (MAX=15), PRE_DIV=1, BRTH_DIV=1, BLINK_DIV=2, ACTIVE_LOW=1.
- Reset release, no writes → owvpwm = 4'b1111 throughout, oprd_end pulses every 15 clocks, olevel = 0, then 1 after first pulse.
- Write ch0 {1,5}, ch1 {1,15}, ch2 {1,0} → from second period on: ch0 low 5 of 15 clocks, ch1 always low, ch2 always high; no partial period in the write period.
- Write ch3 {2,x} → on-time of ch3 equals olevel each period; olevel runs 0..15..0, 15 and 0 each held exactly one period; 30-period cycle.
- Write ch1 {3,8} → ch1 low 8 clocks in two consecutive periods, high for next two, repeating.
- Write to iaddr=4 (AW=2 wraps: use NCH=3 instance, iaddr=3) → no channel changes; write coinciding with period_end → applied one period later.
- Assert irst mid-period with channels active → next edge all outputs 1, oprd_end 0, olevel 0; modes cleared (outputs stay 1 after release).
